down_count_monitor: RTL

Sampling monitor that sits directly downstream of the 3-bit asynchronous (ripple) down counter. It brings the counter's ripple-clocked Q bus into the system clock domain, rejects ripple glitches, and publishes a clean count value. It also flags each 0→max wrap, counts completed wraps, and latches an error if the observed sequence is not a legal down-count. Consumers in the system domain use its outputs instead of touching Q directly.

---
 rtl/down_count_pkg.sv | 23 ++
 rtl/down_count_monitor_bit_sync2.sv | 28 ++
 rtl/down_count_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/down_count_pkg.sv
// down_count_pkg
// Shared types and constants for the ripple down-counter monitor.
//   state_t     : monitor FSM states (ST_INIT, ST_TRACK)
//   WIDTH_DEF   : default width of the monitored counter value
//   WRAP_W_DEF  : default width of the wrap counter
//   prev_val()  : value a legal down-count step lands on
package down_count_pkg;

    localparam int WIDTH_DEF  = 3;
    localparam int WRAP_W_DEF = 8;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    // Returns v - 1. Callers truncate the result to their counter width,
    // which yields (v - 1) modulo 2^WIDTH, so 0 maps onto the all-ones value.
    function automatic logic [31:0] prev_val(input logic [31:0] v);
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/down_count_monitor_bit_sync2.sv
// bit_sync2
// Two-flop synchroniser for a bus sampled from a foreign clock domain.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input bus
//   q1    : first-stage sample (metastability settling stage)
//   q     : second-stage, synchronised output
module bit_sync2 #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q1,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/down_count_monitor.sv
// down_count_monitor
// Brings the Q bus of a ripple down counter into the clk domain, drops
// ripple glitches, publishes the committed value, flags and counts
// 0 -> max wraps and latches an error on any illegal committed step.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   q_in       : ripple counter value, asynchronous to clk
//   clr        : synchronous clear of wrap_count and step_err
//   q_sync     : last committed (stable) counter value
//   valid      : high once the first value has been committed
//   wrap_pulse : one-cycle pulse on a committed 0 -> max transition
//   wrap_count : completed wraps, modulo 2^WRAP_W
//   step_err   : sticky flag for an illegal committed transition
module down_count_monitor
    import down_count_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              clr,
    output logic [WIDTH-1:0]  q_sync,
    output logic              valid,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] q_prev;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic             stable;
    state_t           state;

    // stage 1/2: two-flop synchroniser on the raw counter bus
    bit_sync2 #(.W(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (q_in),
        .q1    (s1),
        .q     (s2)
    );

    // The reset value of s2/s3 is not a real sample; the pipeline is only
    // trusted once three edges have pushed q_in samples all the way into s3.
    // Without this, INIT would commit the reset zeros as the first value.
    assign primed = (prime_cnt == 2'd3);
    assign stable = (s2 == s3);
    assign q_prev = WIDTH'(prev_val(32'(q_sync)));

    // stage 3: glitch filter, FSM, classifier and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3         <= '0;
            prime_cnt  <= '0;
            state      <= ST_INIT;
            q_sync     <= '0;
            valid      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            step_err   <= 1'b0;
        end else begin
            s3         <= s2;
            wrap_pulse <= 1'b0;

            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end

            // Commit-time updates below are written later so they win over clr.
            if (clr) begin
                wrap_count <= '0;
                step_err   <= 1'b0;
            end

            case (state)
                ST_INIT: begin
                    if (primed && stable) begin
                        q_sync <= s2;
                        valid  <= 1'b1;
                        state  <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (stable && (s2 != q_sync)) begin
                        q_sync <= s2;
                        if (s2 == q_prev) begin
                            // A legal step out of zero is the wrap to max.
                            if (q_sync == '0) begin
                                wrap_pulse <= 1'b1;
                                wrap_count <= clr ? WRAP_W'(1) : wrap_count + WRAP_W'(1);
                            end
                        end else begin
                            step_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
